// File: rtl/reg_trace_rules.sv
// Trace-trigger rule register block: staged pattern/mask rules committed atomically, per-rule enables, hit counters.
// Latency: read_data one cycle after selected&reg_read; a COMMIT write lands on the rule buses (and pulses O_commit) one edge later.
// Backpressure: none; every front-end strobe is serviced in the cycle it is presented.
// Ports: usb_clk / reset_n (async active-low); reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid in
//   from the USB front end; read_data registered read byte; selected block decode; I_match per-rule hit pulses;
//   O_trace_patterns / O_trace_masks committed rules; O_pattern_enable / O_pattern_trig_enable; O_commit pulse.
// Optional feature: define TRACE_RULE_COUNTERS_EN to build the hit counters, snapshot and COUNT / COUNT_CLEAR.
module reg_trace_rules #(
    parameter int         pADDR_WIDTH   = 21,
    parameter int         pBYTECNT_SIZE = 7,
    parameter int         pBUFFER_SIZE  = 64,
    parameter int         pMATCH_RULES  = 16,
    parameter int         pCOUNT_WIDTH  = 16,
    parameter logic [1:0] pSELECT       = 2'b01
) (
    input  logic                                   usb_clk,
    input  logic                                   reset_n,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
    input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    input  logic [7:0]                             write_data,
    output logic [7:0]                             read_data,
    input  logic                                   reg_read,
    input  logic                                   reg_write,
    input  logic                                   reg_addrvalid,
    output logic                                   selected,
    input  logic [pMATCH_RULES-1:0]                I_match,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_patterns,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_masks,
    output logic [pMATCH_RULES-1:0]                O_pattern_enable,
    output logic [pMATCH_RULES-1:0]                O_pattern_trig_enable,
    output logic                                   O_commit
);
    localparam int BUF_BYTES = pBUFFER_SIZE / 8;
    localparam int EN_BYTES  = (pMATCH_RULES + 7) / 8;

    localparam logic [5:0] ADDR_NAME           = 6'h00;
    localparam logic [5:0] ADDR_REV            = 6'h01;
    localparam logic [5:0] ADDR_RULE_SEL       = 6'h02;
    localparam logic [5:0] ADDR_STAGE_PATTERN  = 6'h03;
    localparam logic [5:0] ADDR_STAGE_MASK     = 6'h04;
    localparam logic [5:0] ADDR_COMMIT         = 6'h05;
    localparam logic [5:0] ADDR_PATTERN_ENABLE = 6'h06;
    localparam logic [5:0] ADDR_TRIG_ENABLE    = 6'h07;
    localparam logic [5:0] ADDR_STATUS         = 6'h0A;

    // NAME byte 0 is the first character, so reading bytes 0..7 in order spells the string.
    localparam logic [63:0] NAME_STR = "TrcRules";

    logic [5:0]              addr;
    logic                    wr_en;
    logic                    rd_en;
    logic                    byte0;
    logic                    sel_valid;
    logic [4:0]              rule_sel;
    logic [4:0]              commit_sel;
    logic                    commit_pend;
    logic                    err;
    logic                    feature_absent;
    logic [pBUFFER_SIZE-1:0] stage_pattern;
    logic [pBUFFER_SIZE-1:0] stage_mask;
    logic [EN_BYTES*8-1:0]   pat_en_pad;
    logic [EN_BYTES*8-1:0]   trig_en_pad;
    logic [7:0]              rd_byte;
    logic                    unused_addr;

    assign addr        = reg_address[5:0];
    assign selected    = reg_addrvalid && (reg_address[7:6] == pSELECT);
    assign wr_en       = selected && reg_write;
    assign rd_en       = selected && reg_read;
    assign byte0       = (reg_bytecnt == '0);
    assign sel_valid   = (int'(rule_sel) < pMATCH_RULES);
    // Only bits [7:0] of the address decode this block; the rest belong to the front end.
    assign unused_addr = ^reg_address;

`ifdef TRACE_RULE_COUNTERS_EN
    localparam int         CNT_BYTES        = pCOUNT_WIDTH / 8;
    localparam logic [5:0] ADDR_COUNT       = 6'h08;
    localparam logic [5:0] ADDR_COUNT_CLEAR = 6'h09;

    logic [pCOUNT_WIDTH-1:0] count [pMATCH_RULES];
    logic [pCOUNT_WIDTH-1:0] snapshot;
    logic [pCOUNT_WIDTH-1:0] sel_count;
    logic                    clr_sel;
    logic                    clr_all;

    assign feature_absent = 1'b0;
    assign clr_sel = wr_en && (addr == ADDR_COUNT_CLEAR) && byte0 && write_data[0];
    assign clr_all = wr_en && (addr == ADDR_COUNT_CLEAR) && byte0 && write_data[1];

    // Live counter of the selected rule; an out-of-range selection reads as 0.
    always_comb begin
        sel_count = '0;
        for (int i = 0; i < pMATCH_RULES; i++) begin
            if (int'(rule_sel) == i) sel_count = count[i];
        end
    end

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < pMATCH_RULES; i++) count[i] <= '0;
            snapshot <= '0;
        end else begin
            for (int i = 0; i < pMATCH_RULES; i++) begin
                // Clear beats a coincident hit; the counter sticks at all-ones.
                if (clr_all || (clr_sel && int'(rule_sel) == i))
                    count[i] <= '0;
                else if (I_match[i] && (count[i] != {pCOUNT_WIDTH{1'b1}}))
                    count[i] <= count[i] + pCOUNT_WIDTH'(1);
            end
            // Byte 0 read freezes the whole value so the upper bytes match it.
            if (rd_en && (addr == ADDR_COUNT) && byte0) snapshot <= sel_count;
        end
    end
`else
    logic unused_match;
    assign unused_match   = ^I_match;
    assign feature_absent = 1'b1;
`endif

    always_comb begin
        rd_byte     = '0;
        pat_en_pad  = '0;
        trig_en_pad = '0;
        pat_en_pad[pMATCH_RULES-1:0]  = O_pattern_enable;
        trig_en_pad[pMATCH_RULES-1:0] = O_pattern_trig_enable;
        case (addr)
            ADDR_NAME:
                for (int b = 0; b < 8; b++)
                    if (int'(reg_bytecnt) == b) rd_byte = NAME_STR[(7-b)*8 +: 8];
            ADDR_REV:      if (byte0) rd_byte = 8'h01;
            ADDR_RULE_SEL: if (byte0) rd_byte = {3'b000, rule_sel};
            ADDR_STAGE_PATTERN:
                for (int b = 0; b < BUF_BYTES; b++)
                    if (int'(reg_bytecnt) == b) rd_byte = stage_pattern[b*8 +: 8];
            ADDR_STAGE_MASK:
                for (int b = 0; b < BUF_BYTES; b++)
                    if (int'(reg_bytecnt) == b) rd_byte = stage_mask[b*8 +: 8];
            ADDR_PATTERN_ENABLE:
                for (int b = 0; b < EN_BYTES; b++)
                    if (int'(reg_bytecnt) == b) rd_byte = pat_en_pad[b*8 +: 8];
            ADDR_TRIG_ENABLE:
                for (int b = 0; b < EN_BYTES; b++)
                    if (int'(reg_bytecnt) == b) rd_byte = trig_en_pad[b*8 +: 8];
`ifdef TRACE_RULE_COUNTERS_EN
            ADDR_COUNT:
                if (byte0) rd_byte = sel_count[7:0];
                else
                    for (int b = 1; b < CNT_BYTES; b++)
                        if (int'(reg_bytecnt) == b) rd_byte = snapshot[b*8 +: 8];
`endif
            ADDR_STATUS:   if (byte0) rd_byte = {feature_absent, 6'b000000, err};
            default:       rd_byte = '0;
        endcase
    end

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            rule_sel              <= '0;
            commit_sel            <= '0;
            commit_pend           <= 1'b0;
            err                   <= 1'b0;
            stage_pattern         <= '0;
            stage_mask            <= '1;
            O_trace_patterns      <= '0;
            O_trace_masks         <= '1;
            O_pattern_enable      <= '0;
            O_pattern_trig_enable <= '0;
            O_commit              <= 1'b0;
            read_data             <= '0;
        end else begin
            read_data   <= rd_en ? rd_byte : 8'h00;
            commit_pend <= 1'b0;
            O_commit    <= commit_pend;
            // Copy happens one edge after the COMMIT write, together with the pulse.
            if (commit_pend) begin
                for (int i = 0; i < pMATCH_RULES; i++) begin
                    if (int'(commit_sel) == i) begin
                        O_trace_patterns[i*pBUFFER_SIZE +: pBUFFER_SIZE] <= stage_pattern;
                        O_trace_masks[i*pBUFFER_SIZE +: pBUFFER_SIZE]    <= stage_mask;
                    end
                end
            end
            if (wr_en) begin
                case (addr)
                    ADDR_RULE_SEL: if (byte0) rule_sel <= write_data[4:0];
                    ADDR_STAGE_PATTERN:
                        for (int b = 0; b < BUF_BYTES; b++)
                            if (int'(reg_bytecnt) == b) stage_pattern[b*8 +: 8] <= write_data;
                    ADDR_STAGE_MASK:
                        for (int b = 0; b < BUF_BYTES; b++)
                            if (int'(reg_bytecnt) == b) stage_mask[b*8 +: 8] <= write_data;
                    ADDR_COMMIT:
                        if (byte0) begin
                            if (sel_valid) begin
                                commit_pend <= 1'b1;
                                commit_sel  <= rule_sel;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    ADDR_PATTERN_ENABLE:
                        for (int i = 0; i < pMATCH_RULES; i++)
                            if (int'(reg_bytecnt) == i / 8) O_pattern_enable[i] <= write_data[i % 8];
                    ADDR_TRIG_ENABLE:
                        for (int i = 0; i < pMATCH_RULES; i++)
                            if (int'(reg_bytecnt) == i / 8) O_pattern_trig_enable[i] <= write_data[i % 8];
                    ADDR_STATUS: if (byte0 && write_data[0]) err <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule
